// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit pipeline: data-memory / serial-IO access over req/ack, branch resolve, MEM/WB register.
// Optional access watchdog enabled with `define MEM_TIMEOUT_EN (errOut tied low otherwise).
module mem_access_stage #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        writeSpecRegIn,
    input  logic              memtoRegIn,
    input  logic              regWriteIn,
    input  logic [1:0]        memReadIn,
    input  logic [1:0]        memWriteIn,
    input  logic              branchIn,
    input  logic              zerobitIn,
    input  logic [15:0]       PCIn,
    input  logic [15:0]       ALUResultIn,
    input  logic [15:0]       dataIn,
    input  logic [2:0]        registerToWriteIdIn,
    output logic              memReq,
    output logic              memWe,
    output logic              memSel,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic              stallOut,
    output logic              branchTakenOut,
    output logic [15:0]       branchTargetOut,
    output logic [1:0]        writeSpecRegOut,
    output logic              memtoRegOut,
    output logic              regWriteOut,
    output logic [2:0]        registerToWriteIdOut,
    output logic [15:0]       ALUResultOut,
    output logic [15:0]       memDataOut,
    output logic              errOut
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

    stateT stateReg, stateNext;

    logic rdAcc, wrAcc, anyAcc, accSel;
    logic finish, timeoutHit;

    // Control fields of the in-flight instruction, committed to MEM/WB on completion
    logic [1:0]  capSpecReg;
    logic        capMemtoReg;
    logic        capRegWrite;
    logic [2:0]  capRegId;
    logic [15:0] capAlu;
    logic        capIsRead;

    assign rdAcc  = (memReadIn == 2'b01) || (memReadIn == 2'b10);
    assign wrAcc  = (memWriteIn == 2'b01) || (memWriteIn == 2'b10);
    assign anyAcc = rdAcc || wrAcc;
    assign accSel = wrAcc ? memWriteIn[1] : memReadIn[1];

    assign branchTakenOut  = branchIn & zerobitIn;
    assign branchTargetOut = PCIn;
    assign stallOut        = (stateReg == WAIT);
    assign finish          = (stateReg == WAIT) && (memAck || timeoutHit);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] waitCntReg;
    logic             errReg;

    assign timeoutHit = (stateReg == WAIT) && (waitCntReg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign errOut     = errReg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            waitCntReg <= '0;
            errReg     <= 1'b0;
        end else begin
            if (stateReg != WAIT)
                waitCntReg <= '0;
            else
                waitCntReg <= waitCntReg + 1'b1;
            // An ack on the deadline cycle still counts as a good completion
            if (timeoutHit && !memAck)
                errReg <= 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign errOut     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            stateReg <= IDLE;
        else
            stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE, DONE: stateNext = anyAcc ? WAIT : IDLE;
            WAIT:       if (memAck || timeoutHit) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            memReq               <= 1'b0;
            memWe                <= 1'b0;
            memSel               <= 1'b0;
            memAddr              <= '0;
            memWData             <= '0;
            writeSpecRegOut      <= '0;
            memtoRegOut          <= 1'b0;
            regWriteOut          <= 1'b0;
            registerToWriteIdOut <= '0;
            ALUResultOut         <= '0;
            memDataOut           <= '0;
            capSpecReg           <= '0;
            capMemtoReg          <= 1'b0;
            capRegWrite          <= 1'b0;
            capRegId             <= '0;
            capAlu               <= '0;
            capIsRead            <= 1'b0;
        end else begin
            case (stateReg)
                IDLE, DONE: begin
                    if (anyAcc) begin
                        memReq          <= 1'b1;
                        memWe           <= wrAcc;
                        memSel          <= accSel;
                        memAddr         <= ALUResultIn[ADDR_W-1:0];
                        memWData        <= dataIn[DATA_W-1:0];
                        capSpecReg      <= writeSpecRegIn;
                        capMemtoReg     <= memtoRegIn;
                        capRegWrite     <= regWriteIn;
                        capRegId        <= registerToWriteIdIn;
                        capAlu          <= ALUResultIn;
                        capIsRead       <= !wrAcc;
                        // Bubble into WB until the access completes
                        regWriteOut     <= 1'b0;
                        writeSpecRegOut <= '0;
                    end else begin
                        writeSpecRegOut      <= writeSpecRegIn;
                        memtoRegOut          <= memtoRegIn;
                        regWriteOut          <= regWriteIn;
                        registerToWriteIdOut <= registerToWriteIdIn;
                        ALUResultOut         <= ALUResultIn;
                        memDataOut           <= '0;
                    end
                end
                WAIT: begin
                    if (finish) begin
                        memReq               <= 1'b0;
                        writeSpecRegOut      <= capSpecReg;
                        memtoRegOut          <= capMemtoReg;
                        regWriteOut          <= capRegWrite;
                        registerToWriteIdOut <= capRegId;
                        ALUResultOut         <= capAlu;
                        if (!capIsRead)
                            memDataOut <= '0;
                        else if (memAck)
                            memDataOut <= memRData[15:0];
                        else
                            memDataOut <= 16'hFFFF;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; the watchdog scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  writeSpecRegIn;
    logic        memtoRegIn, regWriteIn;
    logic [1:0]  memReadIn, memWriteIn;
    logic        branchIn, zerobitIn;
    logic [15:0] PCIn, ALUResultIn, dataIn;
    logic [2:0]  registerToWriteIdIn;
    logic        memReq, memWe, memSel;
    logic [15:0] memAddr, memWData;
    logic        memAck;
    logic [15:0] memRData;
    logic        stallOut, branchTakenOut;
    logic [15:0] branchTargetOut;
    logic [1:0]  writeSpecRegOut;
    logic        memtoRegOut, regWriteOut;
    logic [2:0]  registerToWriteIdOut;
    logic [15:0] ALUResultOut, memDataOut;
    logic        errOut;

    mem_access_stage #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST),
        .writeSpecRegIn(writeSpecRegIn), .memtoRegIn(memtoRegIn), .regWriteIn(regWriteIn),
        .memReadIn(memReadIn), .memWriteIn(memWriteIn), .branchIn(branchIn), .zerobitIn(zerobitIn),
        .PCIn(PCIn), .ALUResultIn(ALUResultIn), .dataIn(dataIn), .registerToWriteIdIn(registerToWriteIdIn),
        .memReq(memReq), .memWe(memWe), .memSel(memSel), .memAddr(memAddr), .memWData(memWData),
        .memAck(memAck), .memRData(memRData), .stallOut(stallOut),
        .branchTakenOut(branchTakenOut), .branchTargetOut(branchTargetOut),
        .writeSpecRegOut(writeSpecRegOut), .memtoRegOut(memtoRegOut), .regWriteOut(regWriteOut),
        .registerToWriteIdOut(registerToWriteIdOut), .ALUResultOut(ALUResultOut),
        .memDataOut(memDataOut), .errOut(errOut)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  spec;
        logic        memtoReg;
        logic        regWrite;
        logic [2:0]  regId;
        logic [15:0] alu;
        logic [15:0] memData;
    } expT;

    expT expQ[$];
    int  total = 0;
    int  bad   = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic setBubble();
        writeSpecRegIn = 2'b00; memtoRegIn = 1'b0; regWriteIn = 1'b0;
        memReadIn = 2'b00; memWriteIn = 2'b00; branchIn = 1'b0; zerobitIn = 1'b0;
        PCIn = 16'h0; ALUResultIn = 16'h0; dataIn = 16'h0; registerToWriteIdIn = 3'd0;
    endtask

    task automatic popCheck(input string tag);
        expT e;
        checkEq({tag, "_qdepth"}, expQ.size(), 1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkEq({tag, "_regWrite"}, regWriteOut, e.regWrite);
            checkEq({tag, "_spec"}, writeSpecRegOut, e.spec);
            checkEq({tag, "_memtoReg"}, memtoRegOut, e.memtoReg);
            checkEq({tag, "_regId"}, registerToWriteIdOut, e.regId);
            checkEq({tag, "_alu"}, ALUResultOut, e.alu);
            checkEq({tag, "_memData"}, memDataOut, e.memData);
        end
        $display("txn %s: regWrite=%0d id=%0d alu=%h memData=%h", tag, regWriteOut,
                 registerToWriteIdOut, ALUResultOut, memDataOut);
    endtask

    // Non-memory instruction: result lands in MEM/WB one edge later, never stalls
    task automatic aluOp(input string tag, input logic regW, input logic [2:0] id,
                         input logic [15:0] alu, input logic [1:0] spec, input logic [1:0] rdCode);
        expT e;
        @(posedge CLK); #1;
        setBubble();
        regWriteIn = regW; registerToWriteIdIn = id; ALUResultIn = alu;
        writeSpecRegIn = spec; memReadIn = rdCode;
        e = '{spec: spec, memtoReg: 1'b0, regWrite: regW, regId: id, alu: alu, memData: 16'h0};
        expQ.push_back(e);
        @(negedge CLK);
        checkEq({tag, "_stall_pre"}, stallOut, 0);
        @(posedge CLK); #1;
        setBubble();
        @(negedge CLK);
        checkEq({tag, "_stall"}, stallOut, 0);
        checkEq({tag, "_memReq"}, memReq, 0);
        popCheck(tag);
    endtask

    // Memory access acked after nWait WAIT cycles
    task automatic memOp(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                         input logic [15:0] addr, input logic [15:0] wdata, input logic regW,
                         input logic [2:0] id, input int nWait, input logic [15:0] rdata);
        expT  e;
        logic isWr, isRd, expSel;
        isWr   = (wr == 2'b01) || (wr == 2'b10);
        isRd   = !isWr;
        expSel = isWr ? wr[1] : rd[1];
        @(posedge CLK); #1;
        setBubble();
        memReadIn = rd; memWriteIn = wr; ALUResultIn = addr; dataIn = wdata;
        regWriteIn = regW; registerToWriteIdIn = id; memtoRegIn = isRd;
        e = '{spec: 2'b00, memtoReg: isRd, regWrite: regW, regId: id, alu: addr,
              memData: isRd ? rdata : 16'h0};
        expQ.push_back(e);
        @(posedge CLK); #1;
        for (int k = 1; k <= nWait; k++) begin
            @(negedge CLK);
            checkEq({tag, "_memReq"}, memReq, 1);
            checkEq({tag, "_memAddr"}, memAddr, addr);
            checkEq({tag, "_memWe"}, memWe, isWr);
            checkEq({tag, "_memSel"}, memSel, expSel);
            checkEq({tag, "_memWData"}, memWData, wdata);
            checkEq({tag, "_stall"}, stallOut, 1);
            checkEq({tag, "_bubble"}, regWriteOut, 0);
            if (k == nWait) begin
                memAck = 1'b1; memRData = rdata;
            end
        end
        @(posedge CLK); #1;
        memAck = 1'b0; memRData = 16'hDEAD;
        setBubble();
        @(negedge CLK);
        checkEq({tag, "_done_stall"}, stallOut, 0);
        checkEq({tag, "_done_memReq"}, memReq, 0);
        popCheck(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=hang exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        expT z;
        RST = 1'b1; memAck = 1'b0; memRData = 16'h0;
        setBubble();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkEq("rst_memReq", memReq, 0);
        checkEq("rst_stall", stallOut, 0);
        checkEq("rst_regWrite", regWriteOut, 0);
        checkEq("rst_alu", ALUResultOut, 0);
        checkEq("rst_memData", memDataOut, 0);
        checkEq("rst_err", errOut, 0);
        RST = 1'b0;

        aluOp("alu", 1'b1, 3'd3, 16'h1234, 2'b00, 2'b00);
        aluOp("alu_spec", 1'b0, 3'd5, 16'hA5A5, 2'b10, 2'b00);
        aluOp("rd11_none", 1'b1, 3'd6, 16'h7777, 2'b00, 2'b11);
        memOp("ram_load", 2'b01, 2'b00, 16'h0040, 16'h0000, 1'b1, 3'd2, 3, 16'hBEEF);
        memOp("io_store", 2'b00, 2'b10, 16'h0003, 16'h0041, 1'b0, 3'd0, 1, 16'h9999);
        memOp("io_load", 2'b10, 2'b00, 16'h0002, 16'h0000, 1'b1, 3'd7, 2, 16'h00C3);
        memOp("wr_wins", 2'b01, 2'b01, 16'h0080, 16'h5A5A, 1'b0, 3'd1, 1, 16'h1111);

        // Branch outputs are combinational
        @(posedge CLK); #1;
        branchIn = 1'b1; zerobitIn = 1'b1; PCIn = 16'h0100;
        #1;
        checkEq("br_taken", branchTakenOut, 1);
        checkEq("br_target", branchTargetOut, 16'h0100);
        zerobitIn = 1'b0;
        #1;
        checkEq("br_not_taken", branchTakenOut, 0);
        $display("txn branch: target=%h", branchTargetOut);
        setBubble();

        // Stray ack while idle must not start anything
        @(posedge CLK); #1;
        memAck = 1'b1; memRData = 16'h4444;
        @(posedge CLK); #1;
        memAck = 1'b0;
        @(negedge CLK);
        checkEq("idle_ack_stall", stallOut, 0);
        checkEq("idle_ack_memReq", memReq, 0);
        checkEq("idle_ack_memData", memDataOut, 0);
        $display("txn idle_ack: stall=%0d", stallOut);

        // Reset in the 2nd WAIT cycle abandons the access
        @(posedge CLK); #1;
        memReadIn = 2'b01; ALUResultIn = 16'h0040; regWriteIn = 1'b1; registerToWriteIdIn = 3'd4;
        z = '{spec: 2'b00, memtoReg: 1'b0, regWrite: 1'b0, regId: 3'd0, alu: 16'h0, memData: 16'h0};
        expQ.push_back(z);
        @(posedge CLK); #1;
        @(negedge CLK);
        checkEq("rstw_stall1", stallOut, 1);
        @(negedge CLK);
        checkEq("rstw_stall2", stallOut, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; setBubble();
        memAck = 1'b1; memRData = 16'hCAFE;
        @(negedge CLK);
        checkEq("rstw_memReq", memReq, 0);
        checkEq("rstw_stall", stallOut, 0);
        popCheck("rst_wait");
        @(posedge CLK); #1;
        memAck = 1'b0;
        @(negedge CLK);
        checkEq("late_ack_stall", stallOut, 0);
        checkEq("late_ack_memReq", memReq, 0);
        checkEq("late_ack_memData", memDataOut, 0);

        aluOp("alu_after_rst", 1'b1, 3'd2, 16'h0F0F, 2'b01, 2'b00);

`ifdef MEM_TIMEOUT_EN
        @(posedge CLK); #1;
        setBubble();
        memReadIn = 2'b01; ALUResultIn = 16'h0200; regWriteIn = 1'b1;
        registerToWriteIdIn = 3'd6; memtoRegIn = 1'b1;
        z = '{spec: 2'b00, memtoReg: 1'b1, regWrite: 1'b1, regId: 3'd6, alu: 16'h0200, memData: 16'hFFFF};
        expQ.push_back(z);
        @(posedge CLK); #1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            checkEq("to_memReq", memReq, 1);
            checkEq("to_stall", stallOut, 1);
            checkEq("to_err_pre", errOut, 0);
        end
        @(posedge CLK); #1;
        setBubble();
        @(negedge CLK);
        checkEq("to_done_memReq", memReq, 0);
        checkEq("to_done_stall", stallOut, 0);
        checkEq("to_err", errOut, 1);
        popCheck("timeout");
        aluOp("alu_after_to", 1'b1, 3'd1, 16'h2222, 2'b00, 2'b00);
        checkEq("to_err_sticky", errOut, 1);
`else
        checkEq("err_tied", errOut, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
